// File: rtl/counter_wrap_extender.sv
// counter_wrap_extender
// Extends an upstream 8-bit counter (behav_counter) to a wide registered count
// by tracking its carry/borrow wraps, and logs every wrap as an event record in
// a small FIFO drained through a valid/ready handshake.
//
// Optional feature macro: COUNTER_EXT_THRESH_EN
//   defined   -> thresh_hit pulses when ext_count rises across THRESHOLD
//   undefined -> thresh_hit is tied 0
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   qd         in   upstream counter value
//   qd_c       in   carry strobe (up-wrap)
//   qd_b       in   borrow strobe (down-wrap)
//   cnt_load   in   upstream counter loaded/cleared; resynchronise wrap to 0
//   ext_count  out  registered {wrap, qd}
//   ext_ovf    out  sticky: wrap counter rolled over
//   proto_err  out  sticky: carry and borrow seen in the same cycle
//   evt_valid  out  event FIFO head valid
//   evt_ready  in   consumer accepts head
//   evt_data   out  {dir, wrap_after}, dir 1 = up, 0 = down
//   evt_lost   out  sticky: event dropped on a full FIFO
//   thresh_hit out  one-cycle threshold-crossing pulse
module counter_wrap_extender #(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned EXT_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned THRESHOLD   = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [COUNT_WIDTH-1:0]           qd,
    input  logic                             qd_c,
    input  logic                             qd_b,
    input  logic                             cnt_load,
    output logic [EXT_WIDTH+COUNT_WIDTH-1:0] ext_count,
    output logic                             ext_ovf,
    output logic                             proto_err,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [EXT_WIDTH:0]               evt_data,
    output logic                             evt_lost,
    output logic                             thresh_hit
);

    localparam int unsigned XW = EXT_WIDTH + COUNT_WIDTH;
    localparam int unsigned DW = EXT_WIDTH + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = PW + 1;

    logic [EXT_WIDTH-1:0] wrap_q, wrap_d;
    logic [XW-1:0]        ext_count_q, ext_count_d;
    logic                 ext_ovf_q, ext_ovf_d;
    logic                 proto_err_q, proto_err_d;
    logic                 evt_lost_q, evt_lost_d;
    logic                 thresh_hit_q, thresh_hit_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]        occ_q, occ_d;
    logic                 evt_valid_q, evt_valid_d;
    logic [DW-1:0]        evt_data_q, evt_data_d;
    logic [DW-1:0]        mem_q [FIFO_DEPTH];

    logic                 up, dn, push, pop, full, push_ok;
    logic [DW-1:0]        push_data;

    // Next-state logic for the wrap counter, flags and event FIFO
    always_comb begin
        up           = qd_c & ~qd_b;
        dn           = qd_b & ~qd_c;
        wrap_d       = wrap_q;
        ext_ovf_d    = ext_ovf_q;
        proto_err_d  = proto_err_q | (qd_c & qd_b);

        if (cnt_load) begin
            wrap_d = '0;
        end else if (up) begin
            wrap_d = wrap_q + EXT_WIDTH'(1);
            if (&wrap_q) ext_ovf_d = 1'b1;
        end else if (dn) begin
            wrap_d = wrap_q - EXT_WIDTH'(1);
            if (wrap_q == '0) ext_ovf_d = 1'b1;
        end

        ext_count_d = {wrap_d, qd};

        push      = (up | dn) & ~cnt_load;
        push_data = {up, wrap_d};
        pop       = evt_valid_q & evt_ready;
        full      = (occ_q == OW'(FIFO_DEPTH));
        // A pop frees the slot in the same cycle, so a full FIFO still accepts
        push_ok   = push & (~full | pop);
        evt_lost_d = evt_lost_q | (push & full & ~pop);

        wr_ptr_d    = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        occ_d       = occ_q + OW'(push_ok) - OW'(pop);
        evt_valid_d = (occ_d != '0);

        // Registered head: bypass the entry being written if it becomes the head
        evt_data_d = evt_data_q;
        if (evt_valid_d) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) evt_data_d = push_data;
            else                                   evt_data_d = mem_q[rd_ptr_d];
        end

`ifdef COUNTER_EXT_THRESH_EN
        // Upward crossing only: previous below, new at or above
        thresh_hit_d = (ext_count_q < XW'(THRESHOLD)) && (ext_count_d >= XW'(THRESHOLD));
`else
        thresh_hit_d = 1'b0;
`endif
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q       <= '0;
            ext_count_q  <= '0;
            ext_ovf_q    <= 1'b0;
            proto_err_q  <= 1'b0;
            evt_lost_q   <= 1'b0;
            thresh_hit_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            evt_valid_q  <= 1'b0;
            evt_data_q   <= '0;
        end else begin
            wrap_q       <= wrap_d;
            ext_count_q  <= ext_count_d;
            ext_ovf_q    <= ext_ovf_d;
            proto_err_q  <= proto_err_d;
            evt_lost_q   <= evt_lost_d;
            thresh_hit_q <= thresh_hit_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            evt_valid_q  <= evt_valid_d;
            evt_data_q   <= evt_data_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign ext_count  = ext_count_q;
    assign ext_ovf    = ext_ovf_q;
    assign proto_err  = proto_err_q;
    assign evt_valid  = evt_valid_q;
    assign evt_data   = evt_data_q;
    assign evt_lost   = evt_lost_q;
    assign thresh_hit = thresh_hit_q;

endmodule

// File: tb/tb_counter_wrap_extender.sv
module tb_counter_wrap_extender;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  qd;
    logic        qd_c, qd_b, cnt_load;
    logic [23:0] ext_count;
    logic        ext_ovf, proto_err, evt_valid, evt_ready, evt_lost, thresh_hit;
    logic [16:0] evt_data;

    logic [16:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          thr_cnt = 0;
    int          thr_base;
    int          thr_exp;

    counter_wrap_extender dut (
        .clk        (clk),
        .rst        (rst),
        .qd         (qd),
        .qd_c       (qd_c),
        .qd_b       (qd_b),
        .cnt_load   (cnt_load),
        .ext_count  (ext_count),
        .ext_ovf    (ext_ovf),
        .proto_err  (proto_err),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_lost   (evt_lost),
        .thresh_hit (thresh_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge; they hold until the next call
    task automatic step(input logic [7:0] q, input logic c, input logic b, input logic l);
        @(posedge clk);
        #1;
        qd = q; qd_c = c; qd_b = b; cnt_load = l;
    endtask

    task automatic idle(input logic [7:0] q);
        step(q, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("evt_valid_after_drain", 64'(evt_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; qd = '0; qd_c = 1'b0; qd_b = 1'b0; cnt_load = 1'b0; evt_ready = 1'b1;

        // Scoreboard monitor and threshold pulse counter
        fork
            forever begin
                @(negedge clk);
                if (thresh_hit === 1'b1) thr_cnt++;
                if (!rst && evt_valid && evt_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", 64'(evt_data), 64'h1_0000_0000);
                    end else begin
                        chk("evt_data", 64'(evt_data), 64'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle: everything zero for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle", 64'({ext_count, ext_ovf, proto_err, evt_valid, evt_data, evt_lost, thresh_hit}), 64'd0);
        end

        // Three carries with qd=0
        for (int i = 1; i <= 3; i++) begin
            step(8'h00, 1'b1, 1'b0, 1'b0);
            exp_q.push_back({1'b1, 16'(i)});
        end
        idle(8'h00);
        @(negedge clk);
        chk("ext_after_3_carries", 64'(ext_count), 64'h00_0300);
        chk("ovf_after_carries", 64'(ext_ovf), 64'd0);
        drain();

        // Resync to 0, then one borrow underflows the wrap counter
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 16'hFFFF});
        idle(8'hFF);
        @(negedge clk);
        chk("ext_after_borrow", 64'(ext_count), 64'hFF_FFFF);
        chk("ovf_after_borrow", 64'(ext_ovf), 64'd1);
        drain();

        // Back-pressure: six carries into a 4-deep FIFO
        step(8'h00, 1'b0, 1'b0, 1'b1);
        evt_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(8'h00, 1'b1, 1'b0, 1'b0);
            if (i <= 4) exp_q.push_back({1'b1, 16'(i)});
        end
        idle(8'h00);
        @(negedge clk);
        chk("evt_lost_full", 64'(evt_lost), 64'd1);
        chk("ext_after_6_carries", 64'(ext_count), 64'h00_0600);
        chk("head_valid_stalled", 64'(evt_valid), 64'd1);
        chk("head_data_stalled", 64'(evt_data), 64'h1_0001);
        repeat (3) @(negedge clk);
        chk("head_data_stable", 64'(evt_data), 64'h1_0001);
        @(posedge clk);
        #1 evt_ready = 1'b1;
        drain();

        // Simultaneous carry and borrow: error flag, no change, no event
        step(8'h00, 1'b1, 1'b1, 1'b0);
        idle(8'h00);
        @(negedge clk);
        chk("proto_err", 64'(proto_err), 64'd1);
        chk("ext_after_proto_err", 64'(ext_count), 64'h00_0600);
        chk("no_evt_proto_err", 64'(evt_valid), 64'd0);

        // Load wins over a carry
        step(8'h10, 1'b1, 1'b0, 1'b1);
        idle(8'h10);
        @(negedge clk);
        chk("ext_after_load_carry", 64'(ext_count), 64'h00_0010);
        chk("no_evt_load", 64'(evt_valid), 64'd0);
        chk("evt_lost_sticky", 64'(evt_lost), 64'd1);

        // Threshold crossing: up across 1000 pulses once, down does not
        thr_base = thr_cnt;
        for (int i = 1; i <= 3; i++) begin
            step(8'h00, 1'b1, 1'b0, 1'b0);
            exp_q.push_back({1'b1, 16'(i)});
        end
        idle(8'hE7);
        idle(8'hE7);
        idle(8'hE8);
        idle(8'hE8);
        idle(8'hE7);
        idle(8'hE7);
        @(negedge clk);
`ifdef COUNTER_EXT_THRESH_EN
        thr_exp = 1;
`else
        thr_exp = 0;
`endif
        chk("ext_after_thresh_walk", 64'(ext_count), 64'h00_03E7);
        chk("thresh_pulses", 64'(thr_cnt - thr_base), 64'(thr_exp));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
